// File: rtl/bitserial_adder.sv
// Bit-serial ripple adder: one full-adder slice processes one bit per clock,
// LSB first, so a WIDTH-bit addition takes WIDTH cycles in RUN followed by a
// single DONE cycle that presents the registered result.
module bitserial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Bit counter only needs to reach WIDTH-1; the last RUN edge is detected
  // by comparison rather than by overflow.
  localparam int                CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Single full-adder slice: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic s;
    logic co;
    s  = x ^ y ^ c;
    co = (x & y) | (x & c) | (y & c);
    return {co, s};
  endfunction

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q,  carry_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   sum_q,    sum_d;
  logic               cout_q,   cout_d;

  logic [1:0]         slice;

  // Next-state and datapath update; every register holds unless its state acts on it.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    slice    = full_add(a_sh_q[0], b_sh_q[0], carry_q);

    case (state_q)
      IDLE: begin
        // Operands are captured only here, so start is ignored elsewhere.
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {slice[0], sum_sh_q[WIDTH-1:1]};
        carry_d  = slice[1];
        cnt_d    = cnt_q + 1'b1;
        // On the final bit the freshly shifted sum and the final carry are
        // committed straight to the output registers, so sum/cout change
        // only at this edge and stay put until the next operation ends.
        if (cnt_q == LAST) begin
          sum_d   = {slice[0], sum_sh_q[WIDTH-1:1]};
          cout_d  = slice[1];
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so an aborted
  // operation leaves a zero result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Status flags decode the registered state only; start never reaches them.
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
